// File: rtl/ps2_ascii_decoder.sv
// PS/2 Set 2 scan-code to ASCII decoder with prefix FSM, Shift tracking and
// a show-ahead output FIFO with sticky overflow flag.
module ps2_ascii_decoder #(
    parameter int FIFO_DEPTH      = 8,
    parameter int HEX_LETTERS     = 1,
    parameter int RAW_PASSTHROUGH = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          scan_valid,
    input  logic [7:0]                    scan_code,
    input  logic                          rd_en,
    output logic [7:0]                    ascii_code,
    output logic                          ascii_valid,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          shift_active
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    typedef struct packed {
        logic       push;
        logic [7:0] data;
    } dec_t;

    state_t state, state_nxt;
    logic   make_n, make_e, brk_n;
    logic   shift_l, shift_r;
    dec_t   dec;

    logic [FIFO_DEPTH-1:0][7:0] mem;
    logic [AW-1:0]              wptr, rptr;
    logic [CW-1:0]              count;
    logic                       empty, full, pop, push;

    // ---------------- prefix FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        make_n    = 1'b0;
        make_e    = 1'b0;
        brk_n     = 1'b0;
        if (scan_valid) begin
            case (state)
                IDLE: begin
                    if (scan_code == 8'hE0)      state_nxt = EXT;
                    else if (scan_code == 8'hF0) state_nxt = BRK;
                    else                         make_n    = 1'b1;
                end
                EXT: begin
                    if (scan_code == 8'hE0)      state_nxt = EXT;
                    else if (scan_code == 8'hF0) state_nxt = EXT_BRK;
                    else begin
                        make_e    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                BRK: begin
                    if (scan_code != 8'hF0) begin
                        brk_n     = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                EXT_BRK: begin
                    // extended breaks carry no state we track
                    if (scan_code != 8'hF0) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // ---------------- Shift tracking ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_l <= 1'b0;
            shift_r <= 1'b0;
        end else begin
            if (make_n && scan_code == 8'h12) shift_l <= 1'b1;
            if (brk_n  && scan_code == 8'h12) shift_l <= 1'b0;
            if (make_n && scan_code == 8'h59) shift_r <= 1'b1;
            if (brk_n  && scan_code == 8'h59) shift_r <= 1'b0;
        end
    end

    assign shift_active = shift_l | shift_r;

    // ---------------- make-code mapping ----------------
    function automatic dec_t letter(input logic [7:0] lc, input logic [7:0] raw, input logic sh);
        dec_t d;
        if (HEX_LETTERS != 0) begin
            d.push = 1'b1;
            d.data = sh ? (lc - 8'h20) : lc;
        end else begin
            d.push = (RAW_PASSTHROUGH != 0);
            d.data = raw;
        end
        return d;
    endfunction

    always_comb begin
        dec.push = 1'b0;
        dec.data = scan_code;
        if (make_n) begin
            dec.push = 1'b1;
            case (scan_code)
                8'h12, 8'h59: dec.push = 1'b0;
                8'h45: dec.data = 8'h30;
                8'h16: dec.data = 8'h31;
                8'h1E: dec.data = 8'h32;
                8'h26: dec.data = 8'h33;
                8'h25: dec.data = 8'h34;
                8'h2E: dec.data = 8'h35;
                8'h36: dec.data = 8'h36;
                8'h3D: dec.data = 8'h37;
                8'h3E: dec.data = 8'h38;
                8'h46: dec.data = 8'h39;
                8'h5A: dec.data = 8'h0D;
                8'h29: dec.data = 8'h20;
                8'h66: dec.data = 8'h08;
                8'h1C: dec = letter(8'h61, scan_code, shift_active);
                8'h32: dec = letter(8'h62, scan_code, shift_active);
                8'h21: dec = letter(8'h63, scan_code, shift_active);
                8'h23: dec = letter(8'h64, scan_code, shift_active);
                8'h24: dec = letter(8'h65, scan_code, shift_active);
                8'h2B: dec = letter(8'h66, scan_code, shift_active);
                default: dec.push = (RAW_PASSTHROUGH != 0);
            endcase
        end else if (make_e && scan_code == 8'h5A) begin
            dec.push = 1'b1;
            dec.data = 8'h0D;
        end
    end

    // ---------------- output FIFO ----------------
    assign empty = (count == '0);
    assign full  = (count == CW'(FIFO_DEPTH));
    assign pop   = rd_en & ~empty;
    // a pop frees the slot the push lands in, so full+pop still accepts
    assign push  = dec.push & (~full | pop);

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= dec.data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (dec.push && !push) overflow <= 1'b1;
        end
    end

    assign ascii_valid = ~empty;
    assign ascii_code  = empty ? 8'h00 : mem[rptr];
    assign fifo_full   = full;
    assign fifo_count  = count;
endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Directed bench: one default decoder plus a raw-passthrough/no-letters variant
// driven from a shared vector table, then hand sequences for FIFO and reset corners.
module tb_ps2_ascii_decoder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scan_valid = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic       rd_en = 1'b0;

    logic [7:0] ascii_code, r_code;
    logic       ascii_valid, r_valid;
    logic       fifo_full, r_full;
    logic [3:0] fifo_count, r_count;
    logic       overflow, r_ovf;
    logic       shift_active, r_shift;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ps2_ascii_decoder dut (
        .clk(clk), .rst_n(rst_n), .scan_valid(scan_valid), .scan_code(scan_code),
        .rd_en(rd_en), .ascii_code(ascii_code), .ascii_valid(ascii_valid),
        .fifo_full(fifo_full), .fifo_count(fifo_count), .overflow(overflow),
        .shift_active(shift_active)
    );

    ps2_ascii_decoder #(.FIFO_DEPTH(8), .HEX_LETTERS(0), .RAW_PASSTHROUGH(1)) dut_raw (
        .clk(clk), .rst_n(rst_n), .scan_valid(scan_valid), .scan_code(scan_code),
        .rd_en(rd_en), .ascii_code(r_code), .ascii_valid(r_valid),
        .fifo_full(r_full), .fifo_count(r_count), .overflow(r_ovf),
        .shift_active(r_shift)
    );

    typedef struct packed {
        logic       v;
        logic [7:0] code;
        logic       rd;
        logic       ev;
        logic [7:0] ecode;
        logic [3:0] ecnt;
        logic       esh;
        logic [7:0] rcode;
        logic [3:0] rcnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic [7:0] c, input logic rd,
                                input logic ev, input logic [7:0] ec, input int cnt,
                                input logic es, input logic [7:0] rc, input int rcnt);
        vec_t t;
        t.v = v; t.code = c; t.rd = rd; t.ev = ev; t.ecode = ec;
        t.ecnt = 4'(cnt); t.esh = es; t.rcode = rc; t.rcnt = 4'(rcnt);
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] c, input logic rd);
        @(negedge clk);
        scan_valid = v; scan_code = c; rd_en = rd;
        @(posedge clk);
        #1;
        scan_valid = 1'b0; rd_en = 1'b0;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, " valid"}, ascii_valid, 0);
        chk({nm, " code"},  ascii_code, 8'h00);
        chk({nm, " count"}, fifo_count, 0);
        chk({nm, " full"},  fifo_full, 0);
        chk({nm, " ovf"},   overflow, 0);
        chk({nm, " shift"}, shift_active, 0);
    endtask

    logic [7:0] drain_exp[8];

    initial begin
        //            v  code   rd ev ecode cnt sh rcode rcnt
        tbl.push_back(mk(1, 8'h16, 0, 1, 8'h31, 1, 0, 8'h31, 1));
        tbl.push_back(mk(1, 8'hF0, 0, 1, 8'h31, 1, 0, 8'h31, 1));
        tbl.push_back(mk(1, 8'h16, 0, 1, 8'h31, 1, 0, 8'h31, 1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 8'h00, 0));
        tbl.push_back(mk(1, 8'h12, 0, 0, 8'h00, 0, 1, 8'h00, 0));
        tbl.push_back(mk(1, 8'h1C, 0, 1, 8'h41, 1, 1, 8'h1C, 1));
        tbl.push_back(mk(1, 8'hF0, 0, 1, 8'h41, 1, 1, 8'h1C, 1));
        tbl.push_back(mk(1, 8'h12, 0, 1, 8'h41, 1, 0, 8'h1C, 1));
        tbl.push_back(mk(1, 8'h1C, 0, 1, 8'h41, 2, 0, 8'h1C, 2));
        tbl.push_back(mk(0, 8'h00, 1, 1, 8'h61, 1, 0, 8'h1C, 1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 8'h00, 0));
        tbl.push_back(mk(1, 8'hE0, 0, 0, 8'h00, 0, 0, 8'h00, 0));
        tbl.push_back(mk(1, 8'h5A, 0, 1, 8'h0D, 1, 0, 8'h0D, 1));
        tbl.push_back(mk(1, 8'hE0, 0, 1, 8'h0D, 1, 0, 8'h0D, 1));
        tbl.push_back(mk(1, 8'h75, 0, 1, 8'h0D, 1, 0, 8'h0D, 1));
        tbl.push_back(mk(1, 8'hE0, 0, 1, 8'h0D, 1, 0, 8'h0D, 1));
        tbl.push_back(mk(1, 8'hF0, 0, 1, 8'h0D, 1, 0, 8'h0D, 1));
        tbl.push_back(mk(1, 8'h5A, 0, 1, 8'h0D, 1, 0, 8'h0D, 1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 8'h00, 0));
        tbl.push_back(mk(1, 8'h59, 0, 0, 8'h00, 0, 1, 8'h00, 0));
        tbl.push_back(mk(1, 8'h2B, 0, 1, 8'h46, 1, 1, 8'h2B, 1));
        tbl.push_back(mk(1, 8'hF0, 0, 1, 8'h46, 1, 1, 8'h2B, 1));
        tbl.push_back(mk(1, 8'h59, 0, 1, 8'h46, 1, 0, 8'h2B, 1));
        tbl.push_back(mk(1, 8'h1D, 0, 1, 8'h46, 1, 0, 8'h2B, 2));
        tbl.push_back(mk(1, 8'h29, 1, 1, 8'h20, 1, 0, 8'h1D, 2));
        tbl.push_back(mk(1, 8'h66, 1, 1, 8'h08, 1, 0, 8'h20, 2));
        tbl.push_back(mk(1, 8'h45, 1, 1, 8'h30, 1, 0, 8'h08, 2));
        tbl.push_back(mk(1, 8'h46, 1, 1, 8'h39, 1, 0, 8'h30, 2));
        tbl.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 8'h39, 1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 8'h00, 0));
        tbl.push_back(mk(1, 8'hE0, 0, 0, 8'h00, 0, 0, 8'h00, 0));
        tbl.push_back(mk(1, 8'h12, 0, 0, 8'h00, 0, 0, 8'h00, 0));

        #12;
        chk_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].code, tbl[i].rd);
            chk($sformatf("row%0d valid", i), ascii_valid, tbl[i].ev);
            chk($sformatf("row%0d code", i),  ascii_code, tbl[i].ecode);
            chk($sformatf("row%0d count", i), fifo_count, tbl[i].ecnt);
            chk($sformatf("row%0d shift", i), shift_active, tbl[i].esh);
            chk($sformatf("row%0d raw code", i),  r_code, tbl[i].rcode);
            chk($sformatf("row%0d raw count", i), r_count, tbl[i].rcnt);
        end
        chk("table ovf", overflow, 0);

        // fill to full, then one more digit is dropped
        begin
            logic [7:0] digs[9];
            digs = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
            for (int k = 0; k < 9; k++) begin
                step(1, digs[k], 0);
                if (k == 7) begin
                    chk("fill full", fifo_full, 1);
                    chk("fill ovf clear", overflow, 0);
                end
            end
        end
        chk("ovf count", fifo_count, 8);
        chk("ovf full", fifo_full, 1);
        chk("ovf flag", overflow, 1);
        chk("ovf head", ascii_code, 8'h31);

        step(1, 8'h45, 1);
        chk("full pushpop count", fifo_count, 8);
        chk("full pushpop ovf", overflow, 1);
        chk("full pushpop head", ascii_code, 8'h32);

        drain_exp = '{8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h30, 8'h00};
        for (int k = 0; k < 8; k++) begin
            step(0, 8'h00, 1);
            chk($sformatf("drain%0d head", k), ascii_code, drain_exp[k]);
        end
        chk("drain valid", ascii_valid, 0);
        chk("drain ovf sticky", overflow, 1);

        // reset after E0 with shift held and an entry queued
        step(1, 8'h12, 0);
        step(1, 8'h16, 0);
        step(1, 8'hE0, 0);
        chk("pre-reset shift", shift_active, 1);
        #2 rst_n = 1'b0;
        #1 chk_idle("mid reset");
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 8'h5A, 0);
        chk("post E0 valid", ascii_valid, 1);
        chk("post E0 code", ascii_code, 8'h0D);
        chk("post E0 count", fifo_count, 1);
        step(0, 8'h00, 1);

        // reset after F0: next byte is a make, not a break
        step(1, 8'hF0, 0);
        #2 rst_n = 1'b0;
        #1 chk_idle("F0 reset");
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 8'h16, 0);
        chk("post F0 code", ascii_code, 8'h31);
        chk("post F0 count", fifo_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
